// File: rtl/clock_div_gen_pkg.sv
// clock_div_gen_pkg: shared constants and helpers for the
// multi-channel clock/tick generator.
package clock_div_gen_pkg;

  localparam int DFLT_NUM_CH    = 4;
  localparam int DFLT_CNT_WIDTH = 8;
  localparam int DFLT_DIV       = 10;

  // A divide ratio of zero parks the channel.
  localparam int DIV_DISABLED = 0;

  // Channel index width; never narrower than one bit.
  function automatic int ch_idx_w(input int n);
    if (n <= 1) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/clock_div_ch.sv
// clock_div_ch: one divider channel of clock_div_gen.
// Holds cnt/div/shadow/pending and the tick/div_clk flops.
//
// Ports:
//   clk, reset   system clock, sync active-high reset
//   run          global enable, 0 freezes the counter
//   sync         phase-align strobe (PHASE_ALIGN_EN only)
//   load         accepted config write for this channel
//   load_div     divide ratio carried by that write
//   pending      shadow holds a ratio not yet applied
//   tick         one-cycle strobe per period
//   div_clk      divided clock, ceil(D/2) high
//
// Macro PHASE_ALIGN_EN adds the sync restart path.
module clock_div_ch
  import clock_div_gen_pkg::*;
#(
  parameter int CNT_WIDTH = DFLT_CNT_WIDTH,
  parameter int DEF_DIV   = DFLT_DIV
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 sync,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_div,
  output logic                 pending,
  output logic                 tick,
  output logic                 div_clk
);

  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] div;
  logic [CNT_WIDTH-1:0] shadow;
  logic [CNT_WIDTH-1:0] div_m1;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic [CNT_WIDTH-1:0] hi_len;
  logic                 enabled;
  logic                 active;
  logic                 wrap;
  logic                 copy;

  always_comb begin
    div_m1  = div - CNT_WIDTH'(1);
    hi_len  = div - (div >> 1);
    enabled = (div != CNT_WIDTH'(DIV_DISABLED));
    active  = run & enabled;
    wrap    = active & (cnt == div_m1);
    cnt_nxt = wrap ? '0 : cnt + CNT_WIDTH'(1);
    // Apply a new ratio only at a period boundary
    // or while nothing is counting, so no runt pulse.
    copy    = pending & (wrap | ~active);
  end

`ifdef PHASE_ALIGN_EN
  logic sync_en;

  // Enable state after sync folds in the shadow.
  always_comb begin
    if (pending) begin
      sync_en = (shadow != CNT_WIDTH'(DIV_DISABLED));
    end else begin
      sync_en = enabled;
    end
  end
`else
  logic unused_sync;

  assign unused_sync = sync;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      div     <= CNT_WIDTH'(DEF_DIV);
      shadow  <= '0;
      pending <= 1'b0;
      tick    <= 1'b0;
      div_clk <= 1'b0;
    end
`ifdef PHASE_ALIGN_EN
    else if (sync) begin
      cnt     <= '0;
      tick    <= 1'b0;
      div_clk <= sync_en;
      if (pending) begin
        div     <= shadow;
        pending <= 1'b0;
      end
    end
`endif
    else begin
      // load only arrives while pending is clear,
      // so it never collides with copy.
      if (load) begin
        shadow  <= load_div;
        pending <= 1'b1;
      end
      if (copy) begin
        div     <= shadow;
        pending <= 1'b0;
      end
      if (copy) begin
        cnt <= '0;
      end else if (active) begin
        cnt <= cnt_nxt;
      end
      tick <= wrap;
      if (active) begin
        div_clk <= (cnt_nxt < hi_len);
      end else if (!enabled) begin
        div_clk <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clock_div_gen.sv
// clock_div_gen: NUM_CH runtime-programmable clock dividers
// with per-channel tick strobes and divided clocks.
//
// Ports:
//   clk, reset    system clock, sync active-high reset
//   i_run         global enable, 0 freezes all counters
//   i_sync        phase-align request
//   i_cfg_valid   config request valid
//   o_cfg_ready   target channel can take a new ratio
//   i_cfg_ch      target channel index
//   i_cfg_div     new ratio, 0 disables the channel
//   o_tick        one-cycle strobe per channel period
//   o_div_clk     divided clock per channel
//
// Macro PHASE_ALIGN_EN enables i_sync; otherwise ignored.
module clock_div_gen
  import clock_div_gen_pkg::*;
#(
  parameter  int NUM_CH    = DFLT_NUM_CH,
  parameter  int CNT_WIDTH = DFLT_CNT_WIDTH,
  parameter  int DEF_DIV   = DFLT_DIV,
  localparam int CH_IDX_W  = ch_idx_w(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_run,
  input  logic                 i_sync,
  input  logic                 i_cfg_valid,
  output logic                 o_cfg_ready,
  input  logic [CH_IDX_W-1:0]  i_cfg_ch,
  input  logic [CNT_WIDTH-1:0] i_cfg_div,
  output logic [NUM_CH-1:0]    o_tick,
  output logic [NUM_CH-1:0]    o_div_clk
);

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] load;

  // Out-of-range channels stay ready and load nothing,
  // so such requests are silently dropped.
  always_comb begin
    o_cfg_ready = 1'b1;
    load        = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (i_cfg_ch == CH_IDX_W'(c)) begin
        o_cfg_ready = ~pending[c];
        load[c]     = i_cfg_valid & ~pending[c];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clock_div_ch #(
      .CNT_WIDTH (CNT_WIDTH),
      .DEF_DIV   (DEF_DIV)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .run      (i_run),
      .sync     (i_sync),
      .load     (load[g]),
      .load_div (i_cfg_div),
      .pending  (pending[g]),
      .tick     (o_tick[g]),
      .div_clk  (o_div_clk[g])
    );
  end

endmodule

// File: tb/tb_clock_div_gen.sv
// tb_clock_div_gen: directed vector bench for clock_div_gen.
// Table of per-step expectations plus reset/sync sequences.
module tb_clock_div_gen;

  localparam int NUM_CH = 4;
  localparam int CW     = 8;
  localparam int IW     = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_run;
  logic          i_sync;
  logic          i_cfg_valid;
  logic          o_cfg_ready;
  logic [IW-1:0] i_cfg_ch;
  logic [CW-1:0] i_cfg_div;
  logic [3:0]    o_tick;
  logic [3:0]    o_div_clk;

  int checks   = 0;
  int failures = 0;

  clock_div_gen #(
    .NUM_CH    (NUM_CH),
    .CNT_WIDTH (CW),
    .DEF_DIV   (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_run       (i_run),
    .i_sync      (i_sync),
    .i_cfg_valid (i_cfg_valid),
    .o_cfg_ready (o_cfg_ready),
    .i_cfg_ch    (i_cfg_ch),
    .i_cfg_div   (i_cfg_div),
    .o_tick      (o_tick),
    .o_div_clk   (o_div_clk)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       run;
    logic       vld;
    logic [1:0] ch;
    logic [7:0] dv;
    int         adv;
    logic [3:0] etick;
    logic [3:0] eclk;
    logic       erdy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input string      nm,
    input logic       run,
    input logic       vld,
    input logic [1:0] ch,
    input logic [7:0] dv,
    input int         adv,
    input logic [3:0] et,
    input logic [3:0] ec,
    input logic       er
  );
    vec_t v;
    v.name  = nm;
    v.run   = run;
    v.vld   = vld;
    v.ch    = ch;
    v.dv    = dv;
    v.adv   = adv;
    v.etick = et;
    v.eclk  = ec;
    v.erdy  = er;
    return v;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(
    input string      nm,
    input logic [3:0] et,
    input logic [3:0] ec,
    input logic       er
  );
    checks++;
    if (o_tick !== et || o_div_clk !== ec ||
        o_cfg_ready !== er) begin
      failures++;
      $display("FAIL %s: tick=%b clk=%b ready=%b want tick=%b clk=%b ready=%b",
               nm, o_tick, o_div_clk, o_cfg_ready,
               et, ec, er);
    end
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [7:0] dv);
    i_cfg_ch    = ch;
    i_cfg_div   = dv;
    i_cfg_valid = 1'b1;
    step(1);
    i_cfg_valid = 1'b0;
  endtask

  initial begin
    int k;

    // n = edges since reset release; all defaults D=10.
    tbl.push_back(mk("t1_n1",   1, 0, 0, 0, 1, 4'b0000, 4'b1111, 1));
    tbl.push_back(mk("t1_n4",   1, 0, 0, 0, 3, 4'b0000, 4'b1111, 1));
    tbl.push_back(mk("t1_n5",   1, 0, 0, 0, 1, 4'b0000, 4'b0000, 1));
    tbl.push_back(mk("t1_n9",   1, 0, 0, 0, 4, 4'b0000, 4'b0000, 1));
    tbl.push_back(mk("t1_n10",  1, 0, 0, 0, 1, 4'b1111, 4'b1111, 1));
    tbl.push_back(mk("t1_n11",  1, 0, 0, 0, 1, 4'b0000, 4'b1111, 1));
    tbl.push_back(mk("t1_n20",  1, 0, 0, 0, 9, 4'b1111, 4'b1111, 1));
    // ch1 -> 3, accepted at n21, applied at ch1 wrap n30
    tbl.push_back(mk("t2_acc",  1, 1, 1, 3, 1, 4'b0000, 4'b1111, 0));
    tbl.push_back(mk("t2_n29",  1, 0, 1, 0, 8, 4'b0000, 4'b0000, 0));
    tbl.push_back(mk("t2_wrap", 1, 0, 1, 0, 1, 4'b1111, 4'b1111, 1));
    tbl.push_back(mk("t2_n31",  1, 0, 1, 0, 1, 4'b0000, 4'b1111, 1));
    tbl.push_back(mk("t2_n32",  1, 0, 1, 0, 1, 4'b0000, 4'b1101, 1));
    tbl.push_back(mk("t2_n33",  1, 0, 1, 0, 1, 4'b0010, 4'b1111, 1));
    tbl.push_back(mk("t2_n36",  1, 0, 1, 0, 3, 4'b0010, 4'b0010, 1));
    tbl.push_back(mk("t2_n40",  1, 0, 1, 0, 4, 4'b1101, 4'b1111, 1));
    // ch2 -> 0 (off after wrap n50), then -> 1
    tbl.push_back(mk("t3_acc0", 1, 1, 2, 0, 1, 4'b0000, 4'b1101, 0));
    tbl.push_back(mk("t3_wrap", 1, 0, 2, 0, 9, 4'b1101, 4'b1101, 1));
    tbl.push_back(mk("t3_off",  1, 0, 2, 0, 1, 4'b0010, 4'b1011, 1));
    tbl.push_back(mk("t3_acc1", 1, 1, 2, 1, 1, 4'b0000, 4'b1011, 0));
    tbl.push_back(mk("t3_copy", 1, 0, 2, 0, 1, 4'b0000, 4'b1001, 1));
    tbl.push_back(mk("t3_d1a",  1, 0, 2, 0, 1, 4'b0110, 4'b1111, 1));
    tbl.push_back(mk("t3_d1b",  1, 0, 2, 0, 1, 4'b0100, 4'b0110, 1));
    // i_run low 7 edges with ch0/ch3 at count 5
    tbl.push_back(mk("t4_hold1",0, 0, 2, 0, 1, 4'b0000, 4'b0110, 1));
    tbl.push_back(mk("t4_hold7",0, 0, 2, 0, 6, 4'b0000, 4'b0110, 1));
    tbl.push_back(mk("t4_n66",  1, 0, 2, 0, 4, 4'b0100, 4'b0100, 1));
    tbl.push_back(mk("t4_tick", 1, 0, 2, 0, 1, 4'b1111, 4'b1111, 1));
    // ch0 -> 7 left pending before reset
    tbl.push_back(mk("t5_acc",  1, 1, 0, 7, 1, 4'b0100, 4'b1111, 0));

    reset       = 1'b1;
    i_run       = 1'b1;
    i_sync      = 1'b0;
    i_cfg_valid = 1'b0;
    i_cfg_ch    = '0;
    i_cfg_div   = '0;
    step(2);
    chk("reset", 4'b0000, 4'b0000, 1'b1);
    reset = 1'b0;

    foreach (tbl[i]) begin
      i_run       = tbl[i].run;
      i_cfg_ch    = tbl[i].ch;
      i_cfg_div   = tbl[i].dv;
      i_cfg_valid = tbl[i].vld;
      step(1);
      i_cfg_valid = 1'b0;
      if (tbl[i].adv > 1) begin
        step(tbl[i].adv - 1);
      end
      chk(tbl[i].name, tbl[i].etick, tbl[i].eclk, tbl[i].erdy);
    end

    // Mid-operation reset drops the pending ch0 update.
    i_cfg_ch = 2'd0;
    reset    = 1'b1;
    step(1);
    chk("t5_reset", 4'b0000, 4'b0000, 1'b1);
    reset = 1'b0;

    k = 0;
    while (k < 30) begin
      step(1);
      k++;
      if (o_tick[0]) break;
    end
    checks++;
    if (k != 10) begin
      failures++;
      $display("FAIL t5_first_tick: edges=%0d want 10", k);
    end
    step(7);
    chk("t5_n17", 4'b0000, 4'b0000, 1'b1);
    step(3);
    chk("t5_n20", 4'b1111, 4'b1111, 1'b1);

    // ch0 -> 4 (n21), ch1 -> 6 (n22), i_sync at n23.
    cfg(2'd0, 8'd4);
    cfg(2'd1, 8'd6);
    i_sync = 1'b1;
    step(1);
    i_sync = 1'b0;
`ifdef PHASE_ALIGN_EN
    chk("t6_sync", 4'b0000, 4'b1111, 1'b1);
    step(4);
    chk("t6_k4",   4'b0001, 4'b1101, 1'b1);
    step(2);
    chk("t6_k6",   4'b0010, 4'b0010, 1'b1);
    step(6);
    chk("t6_k12",  4'b0011, 4'b1111, 1'b1);
`else
    chk("t6_sync", 4'b0000, 4'b1111, 1'b0);
    step(4);
    chk("t6_n27",  4'b0000, 4'b0000, 1'b0);
    step(2);
    chk("t6_n29",  4'b0000, 4'b0000, 1'b0);
    step(6);
    chk("t6_n35",  4'b0000, 4'b0001, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
